// File: rtl/nfi_pkg.sv
// Shared types and helpers for the NFI scheduler.
package nfi_pkg;

   typedef enum logic [1:0] {
      PAUSED,
      RUNNING,
      ARMED,
      STEP_ARMED
   } nfi_state_t;

   // Clock cycles between generations at a given speed level; the slowest level doubles per step.
   function automatic int unsigned nfi_period(input int unsigned base,
                                              input int unsigned num_speeds,
                                              input int unsigned speed);
      return base << (num_speeds - 1 - speed);
   endfunction

endpackage

// File: rtl/nfi_scheduler_if.sv
// Command/status bundle between the UI/engine side and the NFI scheduler.
interface nfi_scheduler_if #(
   parameter int unsigned SPD_W     = 2,
   parameter int unsigned GEN_CNT_W = 16
);
   logic                 i_NFI_allowed;
   logic                 i_cmd_toggle_pause;
   logic                 i_cmd_step;
   logic                 i_cmd_speed_up;
   logic                 i_cmd_speed_down;
   logic                 o_go;
   logic                 o_paused;
   logic [SPD_W-1:0]     o_speed;
   logic [GEN_CNT_W-1:0] o_gen_cnt;

   modport master (
      output i_NFI_allowed, i_cmd_toggle_pause, i_cmd_step, i_cmd_speed_up, i_cmd_speed_down,
      input  o_go, o_paused, o_speed, o_gen_cnt
   );

   modport slave (
      input  i_NFI_allowed, i_cmd_toggle_pause, i_cmd_step, i_cmd_speed_up, i_cmd_speed_down,
      output o_go, o_paused, o_speed, o_gen_cnt
   );
endinterface

// File: rtl/nfi_cmd_edge.sv
// Two-flop synchronizer plus rising-edge detect for one raw command level.
module nfi_cmd_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);
   // [0],[1] synchronize; [2] remembers the previous synchronized level.
   logic [2:0] sync_q;

   // Shift the raw level through the synchronizer and history flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], raw};
      end
   end

   assign pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/nfi_scheduler.sv
// Next-frame-iteration scheduler: paces o_go pulses to the generation engine.
// Build option NFI_CMD_SYNC_EN: synchronize and edge-detect the i_cmd_* inputs.
module nfi_scheduler
   import nfi_pkg::*;
#(
   parameter int unsigned BASE_PERIOD  = 10,
   parameter int unsigned NUM_SPEEDS   = 4,
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned GEN_CNT_W    = 16,
   parameter int unsigned START_PAUSED = 1
) (
   input logic            clk,
   input logic            rst_n,
   nfi_scheduler_if.slave bus
);
   localparam int unsigned SPD_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
   localparam nfi_state_t ResetState = (START_PAUSED != 0) ? PAUSED : RUNNING;
   localparam logic [SPD_W-1:0] SpeedMax = SPD_W'(NUM_SPEEDS - 1);

   nfi_state_t           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SPD_W-1:0]     speed_q, speed_d;
   logic [GEN_CNT_W-1:0] gen_q, gen_d;
   logic                 go_q, go_d;

   logic                 cmd_toggle, cmd_step, cmd_up, cmd_down;
   logic                 up_ok, down_ok, speed_chg, fire;
   logic [CNT_W-1:0]     period;

`ifdef NFI_CMD_SYNC_EN
   nfi_cmd_edge u_edge_toggle (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.i_cmd_toggle_pause),
      .pulse (cmd_toggle)
   );
   nfi_cmd_edge u_edge_step (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.i_cmd_step),
      .pulse (cmd_step)
   );
   nfi_cmd_edge u_edge_up (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.i_cmd_speed_up),
      .pulse (cmd_up)
   );
   nfi_cmd_edge u_edge_down (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.i_cmd_speed_down),
      .pulse (cmd_down)
   );
`else
   assign cmd_toggle = bus.i_cmd_toggle_pause;
   assign cmd_step   = bus.i_cmd_step;
   assign cmd_up     = bus.i_cmd_speed_up;
   assign cmd_down   = bus.i_cmd_speed_down;
`endif

   assign period = CNT_W'(nfi_period(BASE_PERIOD, NUM_SPEEDS, 32'(speed_q)));

   // State register plus period counter, speed level, generation counter and registered go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ResetState;
         cnt_q   <= '0;
         speed_q <= SpeedMax;
         gen_q   <= '0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
         gen_q   <= gen_d;
         go_q    <= go_d;
      end
   end

   // Next-state: speed saturation, FSM transitions and the fire decision.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      speed_d   = speed_q;
      gen_d     = gen_q;
      fire      = 1'b0;
      up_ok     = cmd_up & ~cmd_down & (speed_q != SpeedMax);
      down_ok   = cmd_down & ~cmd_up & (speed_q != '0);
      speed_chg = up_ok | down_ok;

      if (up_ok) begin
         speed_d = speed_q + SPD_W'(1);
      end else if (down_ok) begin
         speed_d = speed_q - SPD_W'(1);
      end

      case (state_q)
         PAUSED: begin
            cnt_d = '0;
            if (cmd_toggle) begin
               state_d = RUNNING;
            end else if (cmd_step) begin
               state_d = STEP_ARMED;
            end
         end
         RUNNING: begin
            if (cmd_toggle) begin
               state_d = PAUSED;
               cnt_d   = '0;
            end else if (cnt_q >= period - CNT_W'(1)) begin
               // Period end is judged on the current speed; a concurrent change cannot skip it.
               if (bus.i_NFI_allowed) begin
                  fire = 1'b1;
               end else begin
                  state_d = ARMED;
               end
            end else if (speed_chg) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ARMED: begin
            if (cmd_toggle) begin
               state_d = PAUSED;
               cnt_d   = '0;
            end else if (bus.i_NFI_allowed) begin
               fire    = 1'b1;
               state_d = RUNNING;
            end
         end
         STEP_ARMED: begin
            if (cmd_toggle) begin
               state_d = PAUSED;
            end else if (bus.i_NFI_allowed) begin
               fire    = 1'b1;
               state_d = PAUSED;
            end
         end
         default: begin
            state_d = PAUSED;
            cnt_d   = '0;
         end
      endcase

      if (fire) begin
         cnt_d = '0;
         gen_d = gen_q + GEN_CNT_W'(1);
      end
      go_d = fire;
   end

   // Outputs are taken straight from registers.
   always_comb begin
      bus.o_go      = go_q;
      bus.o_paused  = (state_q == PAUSED) || (state_q == STEP_ARMED);
      bus.o_speed   = speed_q;
      bus.o_gen_cnt = gen_q;
   end
endmodule

// File: tb/tb_nfi_scheduler.sv
// Randomized, model-checked bench for nfi_scheduler (narrow generation counter to exercise wrap).
module tb_nfi_scheduler;
   localparam int BP = 10;
   localparam int NS = 4;
   localparam int GW = 4;
`ifdef NFI_CMD_SYNC_EN
   localparam int CMD_LAT = 2;
`else
   localparam int CMD_LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   nfi_scheduler_if #(.SPD_W(2), .GEN_CNT_W(GW)) bus ();

   nfi_scheduler #(
      .BASE_PERIOD  (BP),
      .NUM_SPEEDS   (NS),
      .CNT_W        (24),
      .GEN_CNT_W    (GW),
      .START_PAUSED (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: running/paused, an owed generation, elapsed cycles in the period.
   typedef struct packed {
      bit run;
      bit pend;
      bit go;
      int el;
      int spd;
      int gen;
   } mstate_t;

   mstate_t    m;
   logic [3:0] raw, eff, h1, h2, h3;  // {down, up, step, toggle}

   assign raw = {bus.i_cmd_speed_down, bus.i_cmd_speed_up, bus.i_cmd_step, bus.i_cmd_toggle_pause};
`ifdef NFI_CMD_SYNC_EN
   assign eff = h2 & ~h3;
`else
   assign eff = raw;
`endif

   function automatic mstate_t model_next(input mstate_t s, input logic [3:0] e, input logic al);
      mstate_t n;
      int      per;
      bit      chg;
      n      = s;
      n.go   = 1'b0;
      per    = BP * (1 << (NS - 1 - s.spd));
      chg    = (e[2] != e[3]) && (e[2] ? (s.spd < NS - 1) : (s.spd > 0));
      if (e[0]) begin
         n.run  = !s.run && !s.pend;
         n.pend = 1'b0;
         n.el   = 0;
      end else if (s.pend) begin
         if (al) begin
            n.go   = 1'b1;
            n.pend = 1'b0;
            n.el   = 0;
         end
      end else if (s.run) begin
         if (s.el == per - 1) begin
            if (al) begin
               n.go = 1'b1;
               n.el = 0;
            end else begin
               n.pend = 1'b1;
            end
         end else begin
            n.el = chg ? 0 : s.el + 1;
         end
      end else if (e[1]) begin
         n.pend = 1'b1;
      end
      if (chg) n.spd = e[2] ? s.spd + 1 : s.spd - 1;
      if (n.go) n.gen = (s.gen + 1) % (1 << GW);
      return n;
   endfunction

   // Advance the model on every clock; reset mirrors the DUT's asynchronous reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m  <= '{run: 1'b0, pend: 1'b0, go: 1'b0, el: 0, spd: NS - 1, gen: 0};
         h1 <= '0;
         h2 <= '0;
         h3 <= '0;
      end else begin
         m  <= model_next(m, eff, bus.i_NFI_allowed);
         h1 <= raw;
         h2 <= h1;
         h3 <= h2;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("go", int'(bus.o_go), int'(m.go));
         check("paused", int'(bus.o_paused), int'(!m.run || (m.pend && !m.run)));
         check("speed", int'(bus.o_speed), m.spd);
         check("gen_cnt", int'(bus.o_gen_cnt), m.gen);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle command pulse; idx 0 toggle, 1 step, 2 up, 3 down.
   task automatic pulse(input int idx);
      case (idx)
         0: bus.i_cmd_toggle_pause = 1'b1;
         1: bus.i_cmd_step = 1'b1;
         2: bus.i_cmd_speed_up = 1'b1;
         default: bus.i_cmd_speed_down = 1'b1;
      endcase
      @(negedge clk);
      bus.i_cmd_toggle_pause = 1'b0;
      bus.i_cmd_step         = 1'b0;
      bus.i_cmd_speed_up     = 1'b0;
      bus.i_cmd_speed_down   = 1'b0;
      tick(CMD_LAT);
   endtask

   task automatic wait_go(input int bound, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (bus.o_go !== 1'b1 && waited < bound);
      if (bus.o_go !== 1'b1) check("go_timeout", waited, -1);
   endtask

   task automatic count_go(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.o_go === 1'b1) cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   int w, n, g0;

   initial begin
      rst_n                  = 1'b0;
      bus.i_NFI_allowed      = 1'b1;
      bus.i_cmd_toggle_pause = 1'b0;
      bus.i_cmd_step         = 1'b0;
      bus.i_cmd_speed_up     = 1'b0;
      bus.i_cmd_speed_down   = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);

      // Reset state, then idle while paused.
      check("rst_paused", int'(bus.o_paused), 1);
      check("rst_speed", int'(bus.o_speed), 3);
      check("rst_gen", int'(bus.o_gen_cnt), 0);
      count_go(200, n);
      check("idle_no_go", n, 0);

      // Run at full speed.
      pulse(0);
      check("run_unpaused", int'(bus.o_paused), 0);
      wait_go(40, w);
      for (int i = 0; i < 4; i++) begin
         wait_go(40, w);
         check("period_10", w, 10);
      end
      check("gen_5", int'(bus.o_gen_cnt), 5);

      // Slowest speed and saturation.
      for (int i = 0; i < 3; i++) pulse(3);
      check("speed_min", int'(bus.o_speed), 0);
      wait_go(200, w);
      wait_go(200, w);
      check("period_80", w, 80);
      pulse(3);
      check("speed_sat_low", int'(bus.o_speed), 0);
      for (int i = 0; i < 4; i++) pulse(2);
      check("speed_sat_high", int'(bus.o_speed), 3);

      // Engine busy mid-period: wait in ARMED, fire on the first allowed cycle.
      wait_go(100, w);
      tick(5);
      bus.i_NFI_allowed = 1'b0;
      count_go(30, n);
      check("no_go_while_busy", n, 0);
      bus.i_NFI_allowed = 1'b1;
      @(negedge clk);
      check("go_after_allow", int'(bus.o_go), 1);
      wait_go(40, w);
      check("resume_10", w, 10);

      // Single step while paused.
      pulse(0);
      check("paused_again", int'(bus.o_paused), 1);
      bus.i_NFI_allowed = 1'b0;
      pulse(1);
      g0 = int'(bus.o_gen_cnt);
      tick(7);
      bus.i_NFI_allowed = 1'b1;
      @(negedge clk);
      check("step_go", int'(bus.o_go), 1);
      check("step_gen", int'(bus.o_gen_cnt), (g0 + 1) % 16);
      @(negedge clk);
      check("step_go_one_cycle", int'(bus.o_go), 0);
      check("step_back_paused", int'(bus.o_paused), 1);
      count_go(30, n);
      check("step_no_more", n, 0);

      // Step and toggle together: toggle wins.
      bus.i_cmd_step         = 1'b1;
      bus.i_cmd_toggle_pause = 1'b1;
      @(negedge clk);
      bus.i_cmd_step         = 1'b0;
      bus.i_cmd_toggle_pause = 1'b0;
      tick(CMD_LAT);
      check("step_toggle_runs", int'(bus.o_paused), 0);
      count_go(5, n);
      check("step_toggle_no_pulse", n, 0);

      // Generation counter wrap, then reset in the middle of ARMED.
      do_reset();
      pulse(0);
      for (int i = 0; i < 17; i++) wait_go(40, w);
      check("gen_wrap", int'(bus.o_gen_cnt), 1);
      pulse(3);
      bus.i_NFI_allowed = 1'b0;
      tick(30);
      #2 rst_n = 1'b0;
      #1;
      check("arst_go", int'(bus.o_go), 0);
      check("arst_gen", int'(bus.o_gen_cnt), 0);
      check("arst_speed", int'(bus.o_speed), 3);
      check("arst_paused", int'(bus.o_paused), 1);
      @(negedge clk);
      rst_n             = 1'b1;
      bus.i_NFI_allowed = 1'b1;
      @(negedge clk);
      check("release_no_go", int'(bus.o_go), 0);

`ifdef NFI_CMD_SYNC_EN
      // A held raw level is a single command.
      bus.i_cmd_toggle_pause = 1'b1;
      tick(40);
      bus.i_cmd_toggle_pause = 1'b0;
      tick(3);
      check("held_toggle_once", int'(bus.o_paused), 0);
`endif

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         bus.i_NFI_allowed      = ($urandom_range(0, 9) != 0);
         bus.i_cmd_toggle_pause = ($urandom_range(0, 39) == 0);
         bus.i_cmd_step         = ($urandom_range(0, 19) == 0);
         bus.i_cmd_speed_up     = ($urandom_range(0, 29) == 0);
         bus.i_cmd_speed_down   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      bus.i_cmd_toggle_pause = 1'b0;
      bus.i_cmd_step         = 1'b0;
      bus.i_cmd_speed_up     = 1'b0;
      bus.i_cmd_speed_down   = 1'b0;
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
